ap_add_sequencer: RTL and testbench

//  Micro-sequencer for the associative CAM array. Executes one in-place bit-serial ADD
//  (B <= A + B, all rows in parallel) as compare/write passes on the array's Mask/Key/tag.

---
 rtl/ap_pkg.sv | 32 +++
 rtl/ap_add_pass_rom.sv | 27 ++
 rtl/ap_add_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_ap_add_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_pkg.sv
// Shared types for the associative-processor ADD sequencer: FSM states,
// array input_mode encodings and the per-pass compare/flip record.
package ap_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR_CMP,
        S_CLR_WR,
        S_CMP0,
        S_CMP1,
        S_CMP2,
        S_WR,
        S_OVF,
        S_ERR,
        S_DONE
    } state_t;

    localparam logic [2:0] MODE_COMPUTE   = 3'd0;
    localparam logic [2:0] MODE_ROW_X_ROW = 3'd1;
    localparam logic [2:0] MODE_COL_X_COL = 3'd2;
    localparam logic [2:0] MODE_COPY_B    = 3'd3;
    localparam logic [2:0] MODE_COPY_R    = 3'd4;
    localparam logic [2:0] MODE_COPY_A    = 3'd5;

    // pattern bits are {C, B, A}; flip_b/flip_c select the columns rewritten on a match
    typedef struct packed {
        logic [2:0] pattern;
        logic       flip_b;
        logic       flip_c;
    } pass_t;

endpackage

// File: rtl/ap_add_pass_rom.sv
// Truth table of the four bit-serial ADD passes, indexed by pass number.
import ap_pkg::*;

module ap_add_pass_rom (
    input  logic [1:0] pass_idx_i,
    output logic [2:0] pattern_o,
    output logic       flip_b_o,
    output logic       flip_c_o
);

    pass_t entry;

    // Ordered so a row rewritten by one pass can never match a later pass of the same bit
    always_comb begin
        case (pass_idx_i)
            2'd0:    entry = '{pattern: 3'b011, flip_b: 1'b1, flip_c: 1'b1};
            2'd1:    entry = '{pattern: 3'b001, flip_b: 1'b1, flip_c: 1'b0};
            2'd2:    entry = '{pattern: 3'b100, flip_b: 1'b1, flip_c: 1'b1};
            default: entry = '{pattern: 3'b110, flip_b: 1'b1, flip_c: 1'b0};
        endcase
    end

    assign pattern_o = entry.pattern;
    assign flip_b_o  = entry.flip_b;
    assign flip_c_o  = entry.flip_c;

endmodule

// File: rtl/ap_add_sequencer.sv
// In-place bit-serial B <= A + B over all CAM rows via compare/write passes.
// Define AP_SEQ_OVF_EN to add the final-carry OVF state and the ovf output.
import ap_pkg::*;

module ap_add_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_DEPTH     = 16,
    parameter int COL_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rstIn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [COL_ADDR_WIDTH-1:0] cmd_col_a,
    input  logic [COL_ADDR_WIDTH-1:0] cmd_col_b,
    input  logic [COL_ADDR_WIDTH-1:0] cmd_col_c,
    input  logic [COL_ADDR_WIDTH-1:0] cmd_nbits,
    input  logic [DATA_DEPTH-1:0]     tag_row,
    output logic [DATA_WIDTH-1:0]     mask,
    output logic                      key,
    output logic [DATA_DEPTH-1:0]     tag,
    output logic [2:0]                input_mode,
    output logic                      busy,
    output logic                      done,
`ifdef AP_SEQ_OVF_EN
    output logic                      ovf,
`endif
    output logic                      err
);

    localparam int SUM_W = COL_ADDR_WIDTH + 1;
    localparam logic [SUM_W-1:0] WIDTH_LIM = SUM_W'(DATA_WIDTH);

    function automatic logic [DATA_WIDTH-1:0] onehot(input logic [SUM_W-1:0] idx);
        return DATA_WIDTH'(1) << idx;
    endfunction

    state_t                    state_q;
    logic [COL_ADDR_WIDTH-1:0] col_a_q, col_b_q, col_c_q, nbits_q, bit_q, bit_d;
    logic [1:0]                pass_q, romIdx;
    logic [DATA_DEPTH-1:0]     acc_q, tag_q;
    logic [DATA_WIDTH-1:0]     mask_q, flipMask, endMask;
    logic                      key_q, busy_q, done_q, err_q, ready_q, endKey, endDone;
    logic [SUM_W-1:0]          aEnd, bEnd, cmdC, aIdx, bIdx, cIdx;
    logic                      illegal;
    logic [2:0]                romPattern;
    logic                      romFlipB, romFlipC;
    state_t                    endState;
`ifdef AP_SEQ_OVF_EN
    logic                      ovf_q;
`endif

    // Entering CMP0 from WR needs the following pass's key, so look one entry ahead
    assign romIdx = (state_q == S_WR) ? pass_q + 2'd1 : pass_q;

    ap_add_pass_rom u_rom (
        .pass_idx_i (romIdx),
        .pattern_o  (romPattern),
        .flip_b_o   (romFlipB),
        .flip_c_o   (romFlipC)
    );

    always_comb begin
        aEnd    = {1'b0, cmd_col_a} + {1'b0, cmd_nbits};
        bEnd    = {1'b0, cmd_col_b} + {1'b0, cmd_nbits};
        cmdC    = {1'b0, cmd_col_c};
        illegal = (aEnd > WIDTH_LIM) || (bEnd > WIDTH_LIM) ||
                  ((cmdC >= {1'b0, cmd_col_a}) && (cmdC < aEnd)) ||
                  ((cmdC >= {1'b0, cmd_col_b}) && (cmdC < bEnd));
        aIdx     = {1'b0, col_a_q} + {1'b0, bit_q};
        bIdx     = {1'b0, col_b_q} + {1'b0, bit_q};
        cIdx     = {1'b0, col_c_q};
        bit_d    = bit_q + COL_ADDR_WIDTH'(1);
        flipMask = (romFlipB ? onehot(bIdx) : '0) | (romFlipC ? onehot(cIdx) : '0);
    end

`ifdef AP_SEQ_OVF_EN
    assign endState = S_OVF;
    assign endMask  = onehot(cIdx);
    assign endKey   = 1'b1;
    assign endDone  = 1'b0;
`else
    assign endState = S_DONE;
    assign endMask  = '0;
    assign endKey   = 1'b0;
    assign endDone  = 1'b1;
`endif

    // Outputs are registered for the state being entered; tag is only non-zero in write cycles
    always_ff @(posedge clk) begin
        if (rstIn) begin
            state_q <= S_IDLE;
            col_a_q <= '0;
            col_b_q <= '0;
            col_c_q <= '0;
            nbits_q <= '0;
            bit_q   <= '0;
            pass_q  <= '0;
            acc_q   <= '0;
            tag_q   <= '0;
            mask_q  <= '0;
            key_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
`ifdef AP_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            tag_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        col_a_q <= cmd_col_a;
                        col_b_q <= cmd_col_b;
                        col_c_q <= cmd_col_c;
                        nbits_q <= cmd_nbits;
                        bit_q   <= '0;
                        pass_q  <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        err_q   <= 1'b0;
`ifdef AP_SEQ_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                        if (illegal) begin
                            state_q <= S_ERR;
                            mask_q  <= '0;
                            key_q   <= 1'b0;
                        end else begin
                            state_q <= S_CLR_CMP;
                            mask_q  <= onehot(cmdC);
                            key_q   <= 1'b1;
                        end
                    end
                end
                S_CLR_CMP: begin
                    acc_q   <= tag_row;
                    tag_q   <= tag_row;
                    mask_q  <= onehot(cIdx);
                    key_q   <= 1'b0;
                    state_q <= S_CLR_WR;
                end
                S_CLR_WR: begin
                    acc_q <= '1;
                    if (nbits_q == '0) begin
                        state_q <= endState;
                        mask_q  <= endMask;
                        key_q   <= endKey;
                        done_q  <= endDone;
                    end else begin
                        state_q <= S_CMP0;
                        mask_q  <= onehot(cIdx);
                        key_q   <= romPattern[2];
                    end
                end
                S_CMP0: begin
                    acc_q   <= acc_q & tag_row;
                    mask_q  <= onehot(bIdx);
                    key_q   <= romPattern[1];
                    state_q <= S_CMP1;
                end
                S_CMP1: begin
                    acc_q   <= acc_q & tag_row;
                    mask_q  <= onehot(aIdx);
                    key_q   <= romPattern[0];
                    state_q <= S_CMP2;
                end
                S_CMP2: begin
                    acc_q   <= acc_q & tag_row;
                    tag_q   <= acc_q & tag_row;
                    mask_q  <= flipMask;
                    key_q   <= 1'b0;
                    state_q <= S_WR;
                end
                S_WR: begin
                    acc_q  <= '1;
                    pass_q <= pass_q + 2'd1;
                    if (pass_q == 2'd3) begin
                        bit_q <= bit_d;
                    end
                    if ((pass_q == 2'd3) && (bit_d == nbits_q)) begin
                        state_q <= endState;
                        mask_q  <= endMask;
                        key_q   <= endKey;
                        done_q  <= endDone;
                    end else begin
                        state_q <= S_CMP0;
                        mask_q  <= onehot(cIdx);
                        key_q   <= romPattern[2];
                    end
                end
`ifdef AP_SEQ_OVF_EN
                S_OVF: begin
                    ovf_q   <= |tag_row;
                    mask_q  <= '0;
                    key_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
`endif
                S_ERR: begin
                    err_q   <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    err_q   <= 1'b0;
                    mask_q  <= '0;
                    key_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    mask_q  <= '0;
                    key_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = ready_q;
    assign mask       = mask_q;
    assign key        = key_q;
    assign tag        = tag_q;
    assign input_mode = MODE_COMPUTE;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
`ifdef AP_SEQ_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_ap_add_sequencer.sv
// Directed bench for ap_add_sequencer driving a behavioural 16x8 CAM array model.
module tb_ap_add_sequencer;

    localparam int W = 8;
    localparam int D = 16;
`ifdef AP_SEQ_OVF_EN
    localparam int OVF_EXTRA = 1;
`else
    localparam int OVF_EXTRA = 0;
`endif

    logic         clk;
    logic         rstIn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_col_a, cmd_col_b, cmd_col_c, cmd_nbits;
    logic [D-1:0] tag_row;
    logic [W-1:0] mask;
    logic         key;
    logic [D-1:0] tag;
    logic [2:0]   input_mode;
    logic         busy, done, err;
`ifdef AP_SEQ_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    ap_add_sequencer #(.DATA_WIDTH(W), .DATA_DEPTH(D), .COL_ADDR_WIDTH(3)) dut (
        .clk        (clk),
        .rstIn      (rstIn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_col_a  (cmd_col_a),
        .cmd_col_b  (cmd_col_b),
        .cmd_col_c  (cmd_col_c),
        .cmd_nbits  (cmd_nbits),
        .tag_row    (tag_row),
        .mask       (mask),
        .key        (key),
        .tag        (tag),
        .input_mode (input_mode),
        .busy       (busy),
        .done       (done),
`ifdef AP_SEQ_OVF_EN
        .ovf        (ovf),
`endif
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CAM array model: masked compare against broadcast key, flip tag&mask bits every edge
    logic [W-1:0] arr     [D];
    logic [W-1:0] loadImg [D];
    logic         loadReq;

    always @(posedge clk) begin
        for (int r = 0; r < D; r++) begin
            if (loadReq) arr[r] <= loadImg[r];
            else if (tag[r]) arr[r] <= arr[r] ^ mask;
        end
    end

    always_comb begin
        for (int r = 0; r < D; r++) begin
            tag_row[r] = ((arr[r] & mask) == (key ? mask : 8'h00));
        end
    end

    typedef struct {
        logic [2:0] a, b, c, n;
        logic [7:0] aVal, bVal;
        logic       cInit;
        logic       expErr;
        logic [7:0] expB;
        logic       expC;
        int         expLat;
    } vec_t;

    vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic clearImg();
        for (int r = 0; r < D; r++) loadImg[r] = 8'h00;
    endtask

    task automatic loadArray();
        loadReq = 1'b1;
        @(posedge clk);
        #1;
        loadReq = 1'b0;
    endtask

    function automatic logic isWrCycle(input int lat, input int n, input logic isErr);
        if (isErr) return 1'b0;
        return (lat == 2) || (lat >= 3 && lat < 3 + 16 * n && ((lat - 3) % 4) == 3);
    endfunction

    // Issues one command and follows it to done, recording latency and protocol health
    task automatic runCmd(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                          input logic [2:0] n, input logic isErr,
                          output int lat, output logic gotErr, output logic protoOk);
        protoOk = 1'b1;
        gotErr  = 1'b0;
        @(posedge clk);
        #1;
        if (!cmd_ready) protoOk = 1'b0;
        cmd_col_a = a;
        cmd_col_b = b;
        cmd_col_c = c;
        cmd_nbits = n;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 300) begin
            if (tag != '0 && !isWrCycle(lat, int'(n), isErr)) protoOk = 1'b0;
            if (isErr && mask != '0) protoOk = 1'b0;
            if (cmd_ready || !busy) protoOk = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        gotErr = err;
        if (!busy || cmd_ready || tag != '0) protoOk = 1'b0;
        @(posedge clk);
        #1;
        if (done || !cmd_ready || busy) protoOk = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int         lat;
        logic       gotErr, ok;
        logic [7:0] img, fm, others;
        img = (v.aVal << v.a) | (v.bVal << v.b) | (8'(v.cInit) << v.c);
        fm  = 8'((9'd1 << v.n) - 9'd1);
        clearImg();
        loadImg[0] = img;
        loadArray();
        runCmd(v.a, v.b, v.c, v.n, v.expErr, lat, gotErr, ok);
        checkOutput($sformatf("v%0d latency", idx), lat, v.expLat + (v.expErr ? 0 : OVF_EXTRA));
        checkOutput($sformatf("v%0d err", idx), gotErr, v.expErr);
        checkOutput($sformatf("v%0d protocol", idx), ok, 1'b1);
        checkOutput($sformatf("v%0d resultB", idx), (arr[0] >> v.b) & fm, v.expB);
        checkOutput($sformatf("v%0d carry", idx), arr[0][v.c], v.expC);
        if (v.expErr) checkOutput($sformatf("v%0d row untouched", idx), arr[0], img);
        others = 8'h00;
        for (int r = 1; r < D; r++) others |= arr[r];
        checkOutput($sformatf("v%0d other rows", idx), others, 8'h00);
    endtask

    initial begin
        int   lat;
        logic gotErr, ok, sawDone;

        //            a     b     c     n     A      B      cI    err   expB   C     lat
        vecs[0]  = '{3'd0, 3'd3, 3'd6, 3'd3, 8'd3, 8'd2, 1'b0, 1'b0, 8'd5, 1'b0, 51};
        vecs[1]  = '{3'd0, 3'd3, 3'd6, 3'd3, 8'd7, 8'd7, 1'b0, 1'b0, 8'd6, 1'b1, 51};
        vecs[2]  = '{3'd4, 3'd0, 3'd3, 3'd3, 8'd5, 8'd6, 1'b0, 1'b0, 8'd3, 1'b1, 51};
        vecs[3]  = '{3'd0, 3'd1, 3'd2, 3'd1, 8'd1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b1, 19};
        vecs[4]  = '{3'd0, 3'd4, 3'd3, 3'd3, 8'd5, 8'd1, 1'b0, 1'b0, 8'd6, 1'b0, 51};
        vecs[5]  = '{3'd0, 3'd2, 3'd7, 3'd2, 8'd3, 8'd3, 1'b1, 1'b0, 8'd2, 1'b1, 35};
        vecs[6]  = '{3'd0, 3'd5, 3'd4, 3'd3, 8'd2, 8'd3, 1'b1, 1'b0, 8'd5, 1'b0, 51};
        vecs[7]  = '{3'd0, 3'd3, 3'd4, 3'd3, 8'd3, 8'd2, 1'b0, 1'b1, 8'd2, 1'b1, 2};
        vecs[8]  = '{3'd6, 3'd0, 3'd5, 3'd3, 8'd0, 8'd1, 1'b0, 1'b1, 8'd1, 1'b0, 2};
        vecs[9]  = '{3'd0, 3'd6, 3'd3, 3'd3, 8'd1, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 2};
        vecs[10] = '{3'd0, 3'd3, 3'd1, 3'd3, 8'd0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 2};

        rstIn     = 1'b1;
        cmd_valid = 1'b0;
        cmd_col_a = '0;
        cmd_col_b = '0;
        cmd_col_c = '0;
        cmd_nbits = '0;
        loadReq   = 1'b0;
        clearImg();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset mask", mask, 8'h00);
        checkOutput("reset key", key, 1'b0);
        checkOutput("reset tag", tag, 16'h0000);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset err", err, 1'b0);
        checkOutput("reset ready", cmd_ready, 1'b1);
        checkOutput("reset input_mode", input_mode, 3'd0);
`ifdef AP_SEQ_OVF_EN
        checkOutput("reset ovf", ovf, 1'b0);
`endif
        rstIn = 1'b0;
        loadArray();

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

        // Two-row example: row0 3+2, row1 7+7 (carry out), rest zero
        clearImg();
        loadImg[0] = 8'h13;
        loadImg[1] = 8'h3F;
        loadArray();
        runCmd(3'd0, 3'd3, 3'd6, 3'd3, 1'b0, lat, gotErr, ok);
        checkOutput("example latency", lat, 51 + OVF_EXTRA);
        checkOutput("example protocol", ok, 1'b1);
        checkOutput("example row0", arr[0], 8'h2B);
        checkOutput("example row1", arr[1], 8'h77);
        checkOutput("example row9", arr[9], 8'h00);
`ifdef AP_SEQ_OVF_EN
        checkOutput("example ovf", ovf, 1'b1);
`endif

        // N=0 only clears the carry column
        clearImg();
        loadImg[2] = 8'h40;
        loadImg[5] = 8'h45;
        loadArray();
        runCmd(3'd0, 3'd3, 3'd6, 3'd0, 1'b0, lat, gotErr, ok);
        checkOutput("n0 latency", lat, 3 + OVF_EXTRA);
        checkOutput("n0 err", gotErr, 1'b0);
        checkOutput("n0 protocol", ok, 1'b1);
        checkOutput("n0 row2", arr[2], 8'h00);
        checkOutput("n0 row5", arr[5], 8'h05);
`ifdef AP_SEQ_OVF_EN
        checkOutput("n0 ovf", ovf, 1'b0);
`endif

        // Reset in the middle of an N=3 op aborts without a done pulse
        clearImg();
        loadImg[0] = 8'h13;
        loadArray();
        cmd_col_a = 3'd0;
        cmd_col_b = 3'd3;
        cmd_col_c = 3'd6;
        cmd_nbits = 3'd3;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        sawDone   = 1'b0;
        for (int cyc = 1; cyc < 20; cyc++) begin
            if (done) sawDone = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("abort busy before", busy, 1'b1);
        rstIn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort ready", cmd_ready, 1'b1);
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort mask", mask, 8'h00);
        checkOutput("abort tag", tag, 16'h0000);
        rstIn = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (done || busy) sawDone = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("abort no done", sawDone, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
